// File: rtl/ysyx_23060240_core_seq.sv
// Multi-cycle instruction sequencer: owns PC and IR, drives the fetch and
// load/store handshakes and issues one register-file write pulse per instruction.
module ysyx_23060240_core_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_ready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_ready,
  input  logic        lsu_rvalid,
  input  logic [31:0] lsu_rdata,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] ld_data,
  output logic        rf_we,
  output logic        halt,
  output logic        illegal,
  output logic        bus_err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_WAIT_I, S_EXEC, S_MEM, S_WAIT_D, S_WB, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          is_store, wb_we;
  logic          op_load, op_store, op_write, op_branch, is_ebreak;
  logic          timed_out, waiting, i_take, d_take, set_ill, set_err;

  always_comb begin
    op_load   = (inst[6:0] == 7'b0000011);
    op_store  = (inst[6:0] == 7'b0100011);
    op_branch = (inst[6:0] == 7'b1100011);
    op_write  = inst[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111, 7'b0010011, 7'b0110011};
    is_ebreak = (inst == 32'h0010_0073);
  end

  always_comb begin
    state_nxt = state;
    set_ill   = 1'b0;
    set_err   = 1'b0;
    timed_out = (cnt == CNT_LAST);
    waiting   = (state == S_FETCH) || (state == S_WAIT_I) ||
                (state == S_MEM)   || (state == S_WAIT_D);
    i_take    = ((state == S_FETCH) && ifu_ready && ifu_rvalid) ||
                ((state == S_WAIT_I) && ifu_rvalid);
    d_take    = ((state == S_MEM) && lsu_ready && lsu_rvalid) ||
                ((state == S_WAIT_D) && lsu_rvalid);
    case (state)
      S_RST:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (ifu_ready)      state_nxt = ifu_rvalid ? S_EXEC : S_WAIT_I;
        else if (timed_out) begin state_nxt = S_HALT; set_err = 1'b1; end
      end
      S_WAIT_I: begin
        if (ifu_rvalid)     state_nxt = S_EXEC;
        else if (timed_out) begin state_nxt = S_HALT; set_err = 1'b1; end
      end
      S_EXEC: begin
        if (op_load || op_store)        state_nxt = S_MEM;
        else if (op_write || op_branch) state_nxt = S_WB;
        else begin
          state_nxt = S_HALT;
          set_ill   = !is_ebreak;
        end
      end
      S_MEM: begin
        if (lsu_ready)      state_nxt = lsu_rvalid ? S_WB : S_WAIT_D;
        else if (timed_out) begin state_nxt = S_HALT; set_err = 1'b1; end
      end
      S_WAIT_D: begin
        if (lsu_rvalid)     state_nxt = S_WB;
        else if (timed_out) begin state_nxt = S_HALT; set_err = 1'b1; end
      end
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      cnt      <= '0;
      pc       <= RESET_PC;
      inst     <= 32'h0000_0013;
      ld_data  <= '0;
      is_store <= 1'b0;
      wb_we    <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter restarts on every state change, so it never passes CNT_LAST.
      if (state_nxt != state) cnt <= '0;
      else if (waiting)       cnt <= cnt + 1'b1;
      if (i_take)              inst    <= ifu_rdata;
      if (d_take && !is_store) ld_data <= lsu_rdata;
      if (state == S_EXEC) begin
        is_store <= op_store;
        wb_we    <= op_load | op_write;
      end
      if (state == S_WB) pc <= next_pc;
      if (set_ill) illegal <= 1'b1;
      if (set_err) bus_err <= 1'b1;
    end
  end

  assign ifu_req  = (state == S_FETCH);
  assign ifu_addr = pc;
  assign lsu_req  = (state == S_MEM);
  assign lsu_wen  = (state == S_MEM) && is_store;
  assign rf_we    = (state == S_WB) && wb_we;
  assign halt     = (state == S_HALT);

endmodule

// File: tb/tb_ysyx_23060240_core_seq.sv
// Directed bench for the instruction sequencer: per-instruction vector table
// driven through a cycle-level bus responder, plus reset/timeout sequences.
module tb_ysyx_23060240_core_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req, ifu_ready, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_wen, lsu_ready, lsu_rvalid;
  logic [31:0] lsu_rdata, next_pc, pc, inst, ld_data;
  logic        rf_we, halt, illegal, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_23060240_core_seq #(.RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .next_pc(next_pc), .pc(pc), .inst(inst), .ld_data(ld_data),
    .rf_we(rf_we), .halt(halt), .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct {
    logic        rst;
    logic [31:0] inst, npc;
    int          irdy, ival, drdy, dval;
    logic [31:0] ldat;
    int          cyc, we, req, wen;
    logic [31:0] pc, ld;
    logic        hlt, ill;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ifu_ready = 1'b0; ifu_rvalid = 1'b0;
    lsu_ready = 1'b0; lsu_rvalid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pc"},      pc, 32'h8000_0000);
    chk({tag, ".inst"},    inst, 32'h0000_0013);
    chk({tag, ".ld_data"}, ld_data, 32'h0);
    chk({tag, ".outs"}, {25'd0, ifu_req, lsu_req, lsu_wen, rf_we, halt, illegal, bus_err}, 32'h0);
  endtask

  // Leaves the DUT observed in its first FETCH cycle.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_insn(input vec_t v, output int cyc, output int wes,
                          output int reqs, output int wens, output logic [31:0] faddr);
    int   ic, dc;
    logic iacc, idone, dacc, ddone, fin;
    ic = 0; dc = 0; iacc = 0; idone = 0; dacc = 0; ddone = 0; fin = 0;
    cyc = -1; wes = 0; reqs = 0; wens = 0; faddr = ifu_addr;
    ifu_rdata = v.inst; next_pc = v.npc; lsu_rdata = v.ldat;
    for (int i = 0; i < 80 && !fin; i++) begin
      if (halt || (i > 0 && ifu_req && idone)) begin
        cyc = i; fin = 1'b1;
      end else begin
        idle_inputs();
        if (rf_we) wes++;
        if (lsu_req) begin reqs++; if (lsu_wen) wens++; end
        if (ifu_req && !iacc) begin
          if (ic == v.irdy) begin
            ifu_ready = 1'b1; iacc = 1'b1; ic = 0;
            if (v.ival == 0) begin ifu_rvalid = 1'b1; idone = 1'b1; end
          end else ic++;
        end else if (iacc && !idone) begin
          ic++;
          if (ic == v.ival) begin ifu_rvalid = 1'b1; idone = 1'b1; end
        end
        if (lsu_req && !dacc) begin
          if (dc == v.drdy) begin
            lsu_ready = 1'b1; dacc = 1'b1; dc = 0;
            if (v.dval == 0) begin lsu_rvalid = 1'b1; ddone = 1'b1; end
          end else dc++;
        end else if (dacc && !ddone) begin
          dc++;
          if (dc == v.dval) begin lsu_rvalid = 1'b1; ddone = 1'b1; end
        end
        step();
      end
    end
    idle_inputs();
  endtask

  initial begin
    int          r_cyc, r_we, r_req, r_wen, bad;
    logic [31:0] r_fa, exp_fa;

    //         rst   inst           npc            irdy ival drdy dval ldat        cyc we req wen pc             ld             hlt  ill
    vt[0]  = '{1'b0, 32'h0050_0093, 32'h8000_0004, 0, 0, 0, 0, 32'h0,           3, 1, 0, 0, 32'h8000_0004, 32'h0,         1'b0, 1'b0};
    vt[1]  = '{1'b0, 32'h0000_2103, 32'h8000_0008, 0, 0, 2, 3, 32'hDEAD_BEEF,   9, 1, 3, 0, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 32'h0020_A023, 32'h8000_000C, 0, 0, 0, 0, 32'h1111_1111,   4, 0, 1, 1, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 32'h0000_0463, 32'h8000_0100, 0, 0, 0, 0, 32'h0,           3, 0, 0, 0, 32'h8000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'h1234_50B7, 32'h8000_0104, 1, 2, 0, 0, 32'h0,           6, 1, 0, 0, 32'h8000_0104, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 32'h0080_00EF, 32'h8000_0200, 0, 0, 0, 0, 32'h0,           3, 1, 0, 0, 32'h8000_0200, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 32'h0000_A183, 32'h8000_0204, 0, 0, 0, 0, 32'h1234_5678,   4, 1, 1, 0, 32'h8000_0204, 32'h1234_5678, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 32'h0011_2223, 32'h8000_0208, 0, 0, 1, 1, 32'h5555_5555,   6, 0, 2, 2, 32'h8000_0208, 32'h1234_5678, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'h0010_0073, 32'h9000_0000, 0, 0, 0, 0, 32'h0,           2, 0, 0, 0, 32'h8000_0208, 32'h1234_5678, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0004, 0, 0, 0, 0, 32'h0,           2, 0, 0, 0, 32'h8000_0000, 32'h0,         1'b1, 1'b1};
    vt[10] = '{1'b1, 32'h00A0_0113, 32'h8000_0004, 7, 0, 0, 0, 32'h0,          10, 1, 0, 0, 32'h8000_0004, 32'h0,         1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h0000_A183, 32'h8000_0008, 0, 0, 7, 8, 32'hCAFE_0001,  19, 1, 8, 0, 32'h8000_0008, 32'hCAFE_0001, 1'b0, 1'b0};
    vt[12] = '{1'b0, 32'h0000_0297, 32'h8000_000C, 0, 0, 0, 0, 32'h0,           3, 1, 0, 0, 32'h8000_000C, 32'hCAFE_0001, 1'b0, 1'b0};
    vt[13] = '{1'b0, 32'h0020_81B3, 32'h8000_0010, 0, 0, 0, 0, 32'h0,           3, 1, 0, 0, 32'h8000_0010, 32'hCAFE_0001, 1'b0, 1'b0};
    vt[14] = '{1'b0, 32'h0000_80E7, 32'h8000_0020, 0, 0, 0, 0, 32'h0,           3, 1, 0, 0, 32'h8000_0020, 32'hCAFE_0001, 1'b0, 1'b0};
    vt[15] = '{1'b1, 32'h0000_0073, 32'h8000_0004, 0, 0, 0, 0, 32'h0,           2, 0, 0, 0, 32'h8000_0000, 32'h0,         1'b1, 1'b1};

    idle_inputs();
    ifu_rdata = '0; lsu_rdata = '0; next_pc = '0;
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    chk("req_before_edge", {31'd0, ifu_req}, 32'd0);
    step();
    chk("first_req", {31'd0, ifu_req}, 32'd1);
    exp_fa = 32'h8000_0000;

    for (int k = 0; k < 16; k++) begin
      if (vt[k].rst) begin
        do_reset();
        exp_fa = 32'h8000_0000;
      end
      run_insn(vt[k], r_cyc, r_we, r_req, r_wen, r_fa);
      chk($sformatf("v%0d.fetch_addr", k), r_fa, exp_fa);
      chk($sformatf("v%0d.cycles", k), 32'(r_cyc), 32'(vt[k].cyc));
      chk($sformatf("v%0d.rf_we", k), 32'(r_we), 32'(vt[k].we));
      chk($sformatf("v%0d.lsu_req", k), 32'(r_req), 32'(vt[k].req));
      chk($sformatf("v%0d.lsu_wen", k), 32'(r_wen), 32'(vt[k].wen));
      chk($sformatf("v%0d.pc", k), pc, vt[k].pc);
      chk($sformatf("v%0d.inst", k), inst, vt[k].inst);
      chk($sformatf("v%0d.ld_data", k), ld_data, vt[k].ld);
      chk($sformatf("v%0d.flags", k), {29'd0, halt, illegal, bus_err}, {29'd0, vt[k].hlt, vt[k].ill, 1'b0});
      if (vt[k].hlt) begin
        bad = 0;
        ifu_ready = 1'b1; ifu_rvalid = 1'b1; lsu_ready = 1'b1; lsu_rvalid = 1'b1;
        for (int j = 0; j < 20; j++) begin
          if (ifu_req || lsu_req || rf_we || !halt || pc !== vt[k].pc || inst !== vt[k].inst) bad++;
          step();
        end
        idle_inputs();
        chk($sformatf("v%0d.halt_absorbing", k), 32'(bad), 32'd0);
      end
      exp_fa = vt[k].pc;
    end

    // Fetch never accepted: HALT must appear exactly 8 cycles after FETCH entry.
    do_reset();
    begin
      int n;
      n = 0;
      while (!halt && n < 40) begin step(); n++; end
      chk("timeout.cycles", 32'(n), 32'd8);
      chk("timeout.flags", {29'd0, halt, illegal, bus_err}, 32'b101);
      chk("timeout.no_req", {31'd0, ifu_req}, 32'd0);
    end

    // Reset arriving while a load waits for data.
    do_reset();
    ifu_rdata = 32'h0000_2103; ifu_ready = 1'b1; ifu_rvalid = 1'b1;
    step();
    idle_inputs();
    step();
    chk("midload.mem_req", {30'd0, lsu_req, lsu_wen}, 32'b10);
    lsu_ready = 1'b1;
    step();
    lsu_ready = 1'b0;
    chk("midload.req_drop", {31'd0, lsu_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload");
    lsu_rdata = 32'hCAFE_F00D; lsu_rvalid = 1'b1;
    step();
    chk("midload.ld_in_reset", ld_data, 32'h0);
    rst_n = 1'b1;
    step();
    chk("midload.refetch", {30'd0, ifu_req, lsu_req}, 32'b10);
    chk("midload.refetch_addr", ifu_addr, 32'h8000_0000);
    step();
    chk("midload.ld_after", ld_data, 32'h0);
    lsu_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_core_seq.md
# ysyx_23060240_core_seq

Multi-cycle instruction sequencer for the NPC core. It owns the PC and the instruction register, and drives the instruction-fetch and load/store bus handshakes. It classifies each fetched instruction by opcode and issues a single register-file write-enable pulse per instruction. The latched `inst` feeds the immediate generator and the decoder; `next_pc` comes back from the datapath's combinational branch/jump logic.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `TIMEOUT`, 255, maximum number of cycles spent waiting in any bus state before a bus error is declared; must be ≥ 2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ifu_req` out 1: fetch request valid.
- `ifu_addr` out 32: fetch address; always equals `pc`.
- `ifu_ready` in 1: fetch request accepted.
- `ifu_rvalid` in 1: fetch data valid.
- `ifu_rdata` in 32: fetched instruction.
- `lsu_req` out 1: data request valid.
- `lsu_wen` out 1: 1 for a store, 0 for a load; valid while `lsu_req` is high.
- `lsu_ready` in 1: data request accepted.
- `lsu_rvalid` in 1: load data valid, or store acknowledge.
- `lsu_rdata` in 32: load data.
- `next_pc` in 32: PC of the next instruction, from the datapath.
- `pc` out 32: current PC.
- `inst` out 32: instruction register.
- `ld_data` out 32: latched load data.
- `rf_we` out 1: register-file write enable, one-cycle pulse.
- `halt` out 1: sticky stop.
- `illegal` out 1: sticky, unknown opcode.
- `bus_err` out 1: sticky, handshake timeout.

## Operation
- States: RST, FETCH, WAIT_I, EXEC, MEM, WAIT_D, WB, HALT.
- RST → FETCH on the first clock after `rst_n` rises.
- **FETCH**
  - `ifu_req`=1.
  - On `ifu_ready`: if `ifu_rvalid` is also high, latch `inst` and go to EXEC; otherwise go to WAIT_I.
- **WAIT_I**: on `ifu_rvalid`, latch `inst` and go to EXEC. Any `ifu_rvalid` seen outside FETCH/WAIT_I is ignored.
- **EXEC**: one cycle; classify `inst[6:0]`:
  - 0000011 (load) → MEM with `lsu_wen`=0.
  - 0100011 (store) → MEM with `lsu_wen`=1.
  - Write class → WB: 0110111, 0010111, 1101111, 1100111, 0010011, 0110011.
  - 1100011 (branch) → WB with no write.
  - `inst`==32'h0010_0073 (ebreak) → HALT.
  - Any other opcode → HALT and set `illegal`.
- **MEM**
  - `lsu_req`=1.
  - On `lsu_ready`: if `lsu_rvalid` is also high, finish; otherwise go to WAIT_D.
  - Finishing means go to WB, and for loads latch `lsu_rdata` into `ld_data`.
- **WAIT_D**: on `lsu_rvalid`, finish as in MEM.
- **WB**
  - `rf_we`=1 for loads and the write class; 0 for stores and branches.
  - `pc` ← `next_pc`; go to FETCH.
- **HALT**
  - `halt`=1; the state is absorbing until reset.
  - No requests issued; `pc` and `inst` hold.
- **Timeout**
  - A counter clears on every state entry and increments each cycle spent in FETCH, WAIT_I, MEM or WAIT_D.
  - If the counter reaches TIMEOUT-1 and the exit condition of the current state is still false, go to HALT and set `bus_err`.
  - An exit condition true in that same cycle wins over the timeout.
- **Request stability**
  - `ifu_addr`, `lsu_req` and `lsu_wen` are stable while a request is pending.
  - A request drops in the cycle after it is accepted.
- **Output decoding**: all handshake outputs and `rf_we` are decoded from registered state only; none is combinational from bus inputs.
- **Reset**: asynchronous. Mid-transaction reset abandons the transaction; bus responses arriving later are ignored.

## Timing
- **Reset values**
  - `pc`=RESET_PC, `inst`=32'h0000_0013, `ld_data`=0.
  - `ifu_req`=0, `lsu_req`=0, `lsu_wen`=0, `rf_we`=0.
  - `halt`=0, `illegal`=0, `bus_err`=0; state RST.
- First `ifu_req` rises 1 cycle after `rst_n` deasserts.
- **Minimum latency with zero-wait bus** (ready and rvalid together):
  - ALU/branch/jump instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles (FETCH, EXEC, MEM, WB).
  - Each extra wait cycle adds 1.
- `inst` and `ld_data` update on the edge that samples `rvalid`.
- `pc` updates on the edge leaving WB; `next_pc` is sampled during WB.
- `rf_we` is high exactly one cycle per write-class instruction or load, and never in any other state.
- A timeout in FETCH with no `ifu_ready` ever: HALT is entered TIMEOUT cycles after FETCH entry.

## Test plan
- **ALU fetch, zero-wait**: release reset, return `inst`=32'h0050_0093 with ready and rvalid together, `next_pc`=32'h8000_0004 → `ifu_addr`=32'h8000_0000; `rf_we` pulses 1 cycle in cycle 3; `pc`=32'h8000_0004 afterwards.
- **Load with waits**: `inst`=32'h0000_2103; `lsu_ready` after 2 cycles, `lsu_rvalid` 3 cycles later with data 32'hDEAD_BEEF → `lsu_wen`=0 throughout; `ld_data`=32'hDEAD_BEEF; single `rf_we` pulse.
- **Store/branch**: `inst`=32'h0020_A023 (store), then 32'h0000_0463 (branch) → `lsu_wen`=1 for the store; `rf_we` never asserts; `pc` follows `next_pc` each time.
- **ebreak and illegal**
  - `inst`=32'h0010_0073 → `halt`=1, `illegal`=0; no further `ifu_req`.
  - After reset, `inst`=32'hFFFF_FFFF → `halt`=1, `illegal`=1.
- **Timeout**: TIMEOUT=8 with `ifu_ready` held 0 → HALT with `bus_err`=1 exactly 8 cycles after FETCH entry. With `ifu_ready` rising in the 8th cycle instead → normal progress, no error.
- **Reset mid-load**: assert `rst_n`=0 while in WAIT_D, and pulse `lsu_rvalid` afterwards → all outputs return to reset values; `ld_data` stays 0; fetch restarts at RESET_PC.
